// File: rtl/addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_pkg : shared state encoding and sizing helper for addsub_seq  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Chunk index needs at least one bit even when a single chunk covers WIDTH.
  function automatic int idx_width(input int nchunk);
    if (nchunk <= 1) return 1;
    return $clog2(nchunk);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_chunk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_chunk : CHUNK-bit ripple adder slice, exposes carry into MSB  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_seq : multi-cycle add/sub, CHUNK bits per clock, with flags   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] C_LAST = IW'(NCHUNK - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_xa;
  logic [WIDTH-1:0] r_yb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;

  assign w_a    = r_xa[r_idx*CHUNK +: CHUNK];
  assign w_b    = r_yb[r_idx*CHUNK +: CHUNK];
  assign w_last = (r_idx == C_LAST);

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (w_a),
    .b     (w_b),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  // Full result including the chunk being produced this cycle, so the
  // visible outputs can load on the same edge that finishes the last chunk.
  always_comb begin
    w_res_next = r_res;
    w_res_next[r_idx*CHUNK +: CHUNK] = w_sum;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_xa     <= '0;
      r_yb     <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      s        <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction as x + ~y + 1: invert y once here, seed carry with mode.
            r_xa    <= x;
            r_yb    <= y ^ {WIDTH{mode}};
            r_carry <= mode;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          if (w_last) begin
            s        <= w_res_next;
            carryout <= w_cout;
            overflow <= w_cmsb ^ w_cout;
            zero     <= (w_res_next == '0);
            negative <= w_res_next[WIDTH-1];
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_addsub_seq : scoreboard bench for addsub_seq (16/4, 16/16, 8/2)   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_addsub_seq;

  typedef struct {
    int          inst;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] x, y;
  logic        mode;
  logic [2:0]  st;

  logic        busy0, done0, c0, v0, z0, n0;
  logic        busy1, done1, c1, v1, z1, n1;
  logic        busy2, done2, c2, v2, z2, n2;
  logic [15:0] s0, s1;
  logic [7:0]  s2;

  logic [2:0]  dn, bs, co, ov, ze, ne;
  logic [15:0] so [3];

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .resetn(resetn), .start(st[0]), .mode(mode), .x(x), .y(y),
    .busy(busy0), .done(done0), .s(s0), .carryout(c0), .overflow(v0),
    .zero(z0), .negative(n0));

  addsub_seq #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
    .clk(clk), .resetn(resetn), .start(st[1]), .mode(mode), .x(x), .y(y),
    .busy(busy1), .done(done1), .s(s1), .carryout(c1), .overflow(v1),
    .zero(z1), .negative(n1));

  addsub_seq #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .resetn(resetn), .start(st[2]), .mode(mode), .x(x[7:0]), .y(y[7:0]),
    .busy(busy2), .done(done2), .s(s2), .carryout(c2), .overflow(v2),
    .zero(z2), .negative(n2));

  assign dn = {done2, done1, done0};
  assign bs = {busy2, busy1, busy0};
  assign co = {c2, c1, c0};
  assign ov = {v2, v1, v0};
  assign ze = {z2, z1, z0};
  assign ne = {n2, n1, n0};
  assign so[0] = s0;
  assign so[1] = s1;
  assign so[2] = {8'h00, s2};

  function automatic int nch_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic int width_of(input int i);
    return (i == 2) ? 8 : 16;
  endfunction

  function automatic exp_t mk(input int inst, input logic [15:0] sv,
                              input logic c, v, z, n);
    exp_t r;
    r.inst = inst; r.s = sv; r.c = c; r.v = v; r.z = z; r.n = n; r.acc = 0;
    return r;
  endfunction

  // Reference: widened integer sum for carry, operand/result signs for overflow.
  function automatic exp_t model(input int inst, input logic [15:0] xv, yv, input logic m);
    int unsigned w, mk_, xx, yo, yy, full, sv, sb;
    logic xs, ys, ss;
    w    = width_of(inst);
    mk_  = (32'd1 << w) - 1;
    xx   = {16'h0, xv} & mk_;
    yo   = {16'h0, yv} & mk_;
    yy   = m ? (~yo & mk_) : yo;
    full = xx + yy + {31'd0, m};
    sv   = full & mk_;
    sb   = 32'd1 << (w - 1);
    xs   = (xx & sb) != 0;
    ys   = (yo & sb) != 0;
    ss   = (sv & sb) != 0;
    return mk(inst, sv[15:0], ((full >> w) & 1) != 0,
              m ? ((xs != ys) && (ss != xs)) : ((xs == ys) && (ss != xs)),
              sv == 0, ss);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (dn[i]) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: inst %0d got done with no pending op (expected none)", i);
        end else begin
          mon_e = q.pop_front();
          chk("done_inst", i, mon_e.inst);
          chk("result_s", {16'h0, so[i]}, {16'h0, mon_e.s});
          chk("carryout", {31'h0, co[i]}, {31'h0, mon_e.c});
          chk("overflow", {31'h0, ov[i]}, {31'h0, mon_e.v});
          chk("zero", {31'h0, ze[i]}, {31'h0, mon_e.z});
          chk("negative", {31'h0, ne[i]}, {31'h0, mon_e.n});
          chk("latency", cyc - mon_e.acc, nch_of(i));
          chk("busy_in_done", {31'h0, bs[i]}, 32'd1);
        end
      end
    end
  end

  task automatic wait_idle(input int inst);
    int t;
    t = 0;
    while (bs[inst] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bs[inst]) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: inst %0d busy=1 after 100 cycles (expected 0)", inst);
    end
  endtask

  task automatic run_op(input int inst, input logic [15:0] xv, yv, input logic m, input exp_t e);
    exp_t t;
    t = e;
    @(negedge clk);
    x = xv; y = yv; mode = m; st[inst] = 1'b1;
    @(posedge clk);
    #1;
    t.acc = cyc;
    q.push_back(t);
    @(negedge clk);
    st[inst] = 1'b0;
    x = 16'($urandom); y = 16'($urandom); mode = ~m;
    wait_idle(inst);
  endtask

  task automatic run_rand(input int inst, input int count);
    logic [15:0] rx, ry;
    logic        rm;
    for (int k = 0; k < count; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rm = 1'($urandom);
      run_op(inst, rx, ry, rm, model(inst, rx, ry, rm));
    end
  endtask

  initial begin
    exp_t ea, eb;
    int   acc, lowcnt;
    resetn = 1'b0; st = 3'b000; mode = 1'b0; x = 16'h0; y = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_s", {16'h0, s0}, 32'h0);
    chk("reset_flags", {28'h0, c0, v0, z0, n0}, 32'h0);
    chk("reset_busy_done", {30'h0, busy0, done0}, 32'h0);
    resetn = 1'b1;

    run_op(0, 16'h1234, 16'h0FFF, 1'b0, mk(0, 16'h2233, 0, 0, 0, 0));
    run_op(0, 16'h0005, 16'h0007, 1'b1, mk(0, 16'hFFFE, 0, 0, 0, 1));
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, mk(0, 16'h8000, 0, 1, 0, 1));
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, mk(0, 16'h0000, 1, 0, 1, 0));

    // Extra start pulses while busy must not queue or disturb the op in flight.
    @(negedge clk);
    x = 16'h0005; y = 16'h0003; mode = 1'b0; st[0] = 1'b1;
    @(posedge clk);
    #1;
    ea = mk(0, 16'h0008, 0, 0, 0, 0);
    ea.acc = cyc;
    q.push_back(ea);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      st[0] = (i == 1) || (i == 2) || (i == 4);
      x = 16'($urandom); y = 16'($urandom); mode = 1'($urandom);
      if (i == 3) begin
        chk("hold_s_run", {16'h0, s0}, 32'h0);
        chk("hold_zero_run", {31'h0, z0}, 32'd1);
      end
    end
    st[0] = 1'b0;
    wait_idle(0);

    // start held high: second op accepted in the single IDLE cycle after done.
    @(negedge clk);
    x = 16'h1000; y = 16'h0001; mode = 1'b1; st[0] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    ea = mk(0, 16'h0FFF, 1, 0, 0, 0);
    ea.acc = acc;
    eb = mk(0, 16'h0100, 0, 0, 0, 0);
    eb.acc = acc + 6;
    q.push_back(ea);
    q.push_back(eb);
    lowcnt = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) begin x = 16'h00FF; y = 16'h0001; mode = 1'b0; end
      if (i == 7) st[0] = 1'b0;
      if (!bs[0]) lowcnt++;
    end
    chk("busy_low_cycles", lowcnt, 1);
    wait_idle(0);

    // Reset two cycles into an operation aborts it with no done.
    @(negedge clk);
    x = 16'h8000; y = 16'h0001; mode = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_s", {16'h0, s0}, 32'h0);
    chk("abort_flags", {28'h0, c0, v0, z0, n0}, 32'h0);
    chk("abort_busy_done", {30'h0, busy0, done0}, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    run_op(0, 16'h8000, 16'h0001, 1'b1, mk(0, 16'h7FFF, 1, 1, 0, 0));
    run_rand(0, 6);

    run_op(1, 16'h1234, 16'h0FFF, 1'b0, mk(1, 16'h2233, 0, 0, 0, 0));
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, mk(1, 16'h8000, 0, 1, 0, 1));
    run_rand(1, 4);

    run_op(2, 16'h0080, 16'h0001, 1'b1, mk(2, 16'h007F, 1, 1, 0, 0));
    run_op(2, 16'h0005, 16'h0007, 1'b1, mk(2, 16'h00FE, 0, 0, 0, 1));
    run_rand(2, 4);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
